// File: rtl/bcd_cntr_pkg.sv
// Shared types and helpers for the synchronous multi-decade BCD counter.
package bcd_cntr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_cntr_ctrl_digit.sv
// One BCD decade: clear > load > increment/decrement, with combinational carry/borrow out.
module bcd_digit
  import bcd_cntr_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       inc,
  input  logic       dec,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       clr,
  output logic [3:0] q,
  output logic       carry,
  output logic       borrow
);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (ld) begin
      q_d = bcd_clamp(ld_val);
    end else if (inc) begin
      q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
    end else if (dec) begin
      q_d = (q_q == 4'd0) ? BCD_MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q      = q_q;
  assign carry  = inc && (q_q == BCD_MAX);
  assign borrow = dec && (q_q == 4'd0);

endmodule

// File: rtl/bcd_cntr_ctrl.sv
// Start/stop/clear/load sequencer, tick prescaler and decade chain for a BCD counter.
// Optional BCD_CNTR_DOWN_EN adds a `dir` input for down-counting.
module bcd_cntr_ctrl
  import bcd_cntr_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  wrap_en,
`ifdef BCD_CNTR_DOWN_EN
  input  logic                  dir,
`endif
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done,
  output logic                  tc
);

  localparam int                PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0]  PSC_LAST = PSC_W'(PRESCALE - 1);
  localparam int unsigned       ND       = DIGITS;

  state_e           state_q, state_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             tc_q, tc_d;
  logic             step, sat_term, clr_all, ld_all;
  logic             step_up, step_dn, wrap_term;
  logic             all_max, all_zero, at_term, dir_w;

`ifdef BCD_CNTR_DOWN_EN
  assign dir_w = dir;
`else
  assign dir_w = 1'b0;
`endif

  always_comb begin
    all_max  = 1'b1;
    all_zero = 1'b1;
    for (int unsigned i = 0; i < ND; i++) begin
      if (count[4*i +: 4] != BCD_MAX) all_max  = 1'b0;
      if (count[4*i +: 4] != 4'd0)    all_zero = 1'b0;
    end
    at_term = dir_w ? all_zero : all_max;
  end

  always_comb begin
    state_d  = state_q;
    psc_d    = psc_q;
    step     = 1'b0;
    sat_term = 1'b0;
    clr_all  = 1'b0;
    ld_all   = 1'b0;
    if (clear) begin
      state_d = IDLE;
      psc_d   = '0;
      clr_all = 1'b1;
    end else if (load) begin
      state_d = IDLE;
      psc_d   = '0;
      ld_all  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (start && !stop) state_d = RUN;
        RUN: begin
          if (stop) begin
            state_d = IDLE;
          end else if (psc_q == PSC_LAST) begin
            psc_d = '0;
            // Saturating terminal tick freezes the digits instead of stepping them.
            if (at_term && !wrap_en) begin
              sat_term = 1'b1;
              state_d  = DONE;
            end else begin
              step = 1'b1;
            end
          end else begin
            psc_d = psc_q + PSC_W'(1);
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign step_up = step && !dir_w;
  assign step_dn = step && dir_w;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dig
      logic       inc_i, dec_i, carry_o, borrow_o;
      logic [3:0] q_o;
      if (gi == 0) begin : g_first
        assign inc_i = step_up;
        assign dec_i = step_dn;
      end else begin : g_next
        assign inc_i = g_dig[gi-1].carry_o;
        assign dec_i = g_dig[gi-1].borrow_o;
      end
      bcd_digit u_digit (
        .clk    (clk),
        .rstn   (rstn),
        .inc    (inc_i),
        .dec    (dec_i),
        .ld     (ld_all),
        .ld_val (load_val[4*gi +: 4]),
        .clr    (clr_all),
        .q      (q_o),
        .carry  (carry_o),
        .borrow (borrow_o)
      );
      assign count[4*gi +: 4] = q_o;
      if (gi == DIGITS - 1) begin : g_last
        // Carry/borrow out of the top decade marks a wrapping terminal tick.
        assign wrap_term = carry_o | borrow_o;
      end
    end
  endgenerate

  always_comb begin
    tc_d = sat_term | wrap_term;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      psc_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      tc_q    <= tc_d;
    end
  end

  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign tc      = tc_q;

endmodule

// File: tb/tb_bcd_cntr_ctrl.sv
// Self-checking bench for bcd_cntr_ctrl: directed scenarios plus randomized run against a decimal model.
module tb_bcd_cntr_ctrl;

  localparam int ND    = 4;
  localparam int PSC   = 3;
  localparam int MAXV  = 9999;
  localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
  logic [15:0] load_val = '0;
  logic        wrap_en = 1'b0;
  logic        dir = 1'b0;
  logic [15:0] count;
  logic        running, done, tc;

  int checks = 0;
  int failures = 0;

  int m_val = 0, m_psc = 0, m_state = S_IDLE;
  logic m_tc = 1'b0;

  bcd_cntr_ctrl #(.DIGITS(ND), .PRESCALE(PSC)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .wrap_en  (wrap_en),
`ifdef BCD_CNTR_DOWN_EN
    .dir      (dir),
`endif
    .count    (count),
    .running  (running),
    .done     (done),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  function automatic int load_to_int(input logic [15:0] v);
    int r = 0;
    int pw = 1;
    logic [3:0] nib;
    for (int i = 0; i < ND; i++) begin
      nib = v[4*i +: 4];
      if (nib > 4'd9) nib = 4'd9;
      r += int'(nib) * pw;
      pw *= 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] int_to_bcd(input int v);
    logic [15:0] r = '0;
    int x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_step();
    logic down;
`ifdef BCD_CNTR_DOWN_EN
    down = dir;
`else
    down = 1'b0;
`endif
    if (!rstn) begin
      m_val = 0; m_psc = 0; m_state = S_IDLE; m_tc = 1'b0;
    end else begin
      m_tc = 1'b0;
      if (clear) begin
        m_val = 0; m_psc = 0; m_state = S_IDLE;
      end else if (load) begin
        m_val = load_to_int(load_val); m_psc = 0; m_state = S_IDLE;
      end else if (m_state == S_IDLE) begin
        if (start && !stop) m_state = S_RUN;
      end else if (m_state == S_RUN) begin
        if (stop) m_state = S_IDLE;
        else if (m_psc == PSC - 1) begin
          m_psc = 0;
          if ((!down && m_val == MAXV) || (down && m_val == 0)) begin
            m_tc = 1'b1;
            if (!wrap_en) m_state = S_DONE;
            else m_val = down ? MAXV : 0;
          end else begin
            m_val = down ? m_val - 1 : m_val + 1;
          end
        end else begin
          m_psc++;
        end
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    cyc(); cyc();
    checks++;
    if (count !== 16'h0000 || running !== 1'b0 || done !== 1'b0 || tc !== 1'b0) begin
      failures++;
      $display("FAIL reset: count=%h running=%b done=%b tc=%b expected 0000/0/0/0", count, running, done, tc);
    end
    rstn = 1'b1;
    cyc();
  endtask

  task automatic test_count_basic();
    start = 1'b1;
    cyc();
    checks++;
    if (running !== 1'b1 || count !== 16'h0000) begin
      failures++;
      $display("FAIL run_entry: running=%b count=%h expected 1/0000", running, count);
    end
    cyc(); cyc();
    checks++;
    if (count !== 16'h0000) begin
      failures++;
      $display("FAIL early_tick: count=%h expected 0000", count);
    end
    cyc();
    checks++;
    if (count !== 16'h0001) begin
      failures++;
      $display("FAIL first_tick: count=%h expected 0001", count);
    end
    repeat (27) cyc();
    checks++;
    if (count !== 16'h0010 || running !== 1'b1) begin
      failures++;
      $display("FAIL run30: count=%h running=%b expected 0010/1", count, running);
    end
    start = 1'b0; stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks++;
    if (running !== 1'b0 || count !== 16'h0010) begin
      failures++;
      $display("FAIL stop: running=%b count=%h expected 0/0010", running, count);
    end
  endtask

  task automatic test_carry();
    logic [15:0] exp_seq [6];
    exp_seq = '{16'h0999, 16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004};
    wrap_en = 1'b1;
    load = 1'b1; load_val = 16'h0998;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      repeat (PSC) cyc();
      checks++;
      if (count !== exp_seq[k]) begin
        failures++;
        $display("FAIL carry_seq[%0d]: count=%h expected %h", k, count, exp_seq[k]);
      end
    end
  endtask

  task automatic test_saturate();
    wrap_en = 1'b0;
    load = 1'b1; load_val = 16'h9998;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (PSC) cyc();
    checks++;
    if (count !== 16'h9999 || tc !== 1'b0) begin
      failures++;
      $display("FAIL sat_pre: count=%h tc=%b expected 9999/0", count, tc);
    end
    repeat (PSC) cyc();
    checks++;
    if (count !== 16'h9999 || tc !== 1'b1 || done !== 1'b1 || running !== 1'b0) begin
      failures++;
      $display("FAIL sat_term: count=%h tc=%b done=%b running=%b expected 9999/1/1/0", count, tc, done, running);
    end
    cyc();
    checks++;
    if (tc !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL sat_tc_pulse: tc=%b done=%b expected 0/1", tc, done);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || running !== 1'b0) begin
      failures++;
      $display("FAIL done_ignores_start: done=%b running=%b expected 1/0", done, running);
    end
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    checks++;
    if (count !== 16'h0000 || done !== 1'b0 || running !== 1'b0) begin
      failures++;
      $display("FAIL clear_from_done: count=%h done=%b running=%b expected 0000/0/0", count, done, running);
    end
  endtask

  task automatic test_wrap_and_stop();
    wrap_en = 1'b1;
    load = 1'b1; load_val = 16'h9999;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (PSC) cyc();
    checks++;
    if (count !== 16'h0000 || tc !== 1'b1 || running !== 1'b1) begin
      failures++;
      $display("FAIL wrap: count=%h tc=%b running=%b expected 0000/1/1", count, tc, running);
    end
    cyc();
    checks++;
    if (tc !== 1'b0 || running !== 1'b1) begin
      failures++;
      $display("FAIL wrap_tc_pulse: tc=%b running=%b expected 0/1", tc, running);
    end
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks++;
    if (count !== 16'h0000 || running !== 1'b0 || tc !== 1'b0) begin
      failures++;
      $display("FAIL stop_on_tick: count=%h running=%b tc=%b expected 0000/0/0", count, running, tc);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    checks++;
    if (count !== 16'h0001) begin
      failures++;
      $display("FAIL resume_partial: count=%h expected 0001", count);
    end
  endtask

  task automatic test_load_reset();
    load = 1'b1; load_val = 16'h0F3A;
    cyc();
    load = 1'b0;
    checks++;
    if (count !== 16'h0939) begin
      failures++;
      $display("FAIL load_clamp: count=%h expected 0939", count);
    end
    clear = 1'b1; load = 1'b1; load_val = 16'h1234;
    cyc();
    clear = 1'b0; load = 1'b0;
    checks++;
    if (count !== 16'h0000) begin
      failures++;
      $display("FAIL clear_over_load: count=%h expected 0000", count);
    end
    wrap_en = 1'b1;
    load = 1'b1; load_val = 16'h9999;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    rstn = 1'b0;
    cyc();
    checks++;
    if (count !== 16'h0000 || running !== 1'b0 || done !== 1'b0 || tc !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_run: count=%h running=%b done=%b tc=%b expected 0000/0/0/0", count, running, done, tc);
    end
    rstn = 1'b1;
    cyc();
    checks++;
    if (tc !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_tc: tc=%b expected 0", tc);
    end
  endtask

`ifdef BCD_CNTR_DOWN_EN
  task automatic test_down();
    dir = 1'b1; wrap_en = 1'b0;
    load = 1'b1; load_val = 16'h1000;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (PSC) cyc();
    checks++;
    if (count !== 16'h0999) begin
      failures++;
      $display("FAIL down_borrow: count=%h expected 0999", count);
    end
    load = 1'b1; load_val = 16'h0000;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (PSC) cyc();
    checks++;
    if (count !== 16'h0000 || tc !== 1'b1 || done !== 1'b1) begin
      failures++;
      $display("FAIL down_sat: count=%h tc=%b done=%b expected 0000/1/1", count, tc, done);
    end
    dir = 1'b0;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      rstn  = ($urandom_range(0, 199) != 0);
      clear = ($urandom_range(0, 59) == 0);
      load  = ($urandom_range(0, 24) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      start = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 49) == 0) wrap_en = ~wrap_en;
`ifdef BCD_CNTR_DOWN_EN
      if ($urandom_range(0, 29) == 0) dir = ~dir;
`endif
      if ($urandom_range(0, 1) == 0) load_val = 16'($urandom);
      else load_val = {8'h99, 4'h9, 4'($urandom_range(6, 9))};
      cyc();
      checks++;
      if (count !== int_to_bcd(m_val)) begin
        failures++;
        $display("FAIL rnd_count@%0d: count=%h expected %h", n, count, int_to_bcd(m_val));
      end
      checks++;
      if (running !== (m_state == S_RUN) || done !== (m_state == S_DONE)) begin
        failures++;
        $display("FAIL rnd_state@%0d: running=%b done=%b expected state %0d", n, running, done, m_state);
      end
      checks++;
      if (tc !== m_tc) begin
        failures++;
        $display("FAIL rnd_tc@%0d: tc=%b expected %b", n, tc, m_tc);
      end
    end
    rstn = 1'b1; clear = 1'b0; load = 1'b0; stop = 1'b0; start = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_count_basic();
    test_carry();
    test_saturate();
    test_wrap_and_stop();
    test_load_reset();
`ifdef BCD_CNTR_DOWN_EN
    test_down();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
